// File: rtl/bin_to_bcd4.sv
// bin_to_bcd4: shift-and-add-3 binary to 4-digit BCD, one bit per clock.
// Ports: clk_50mhz, reset (async, active-low), bin_in/bin_valid/bin_ready,
//        bcd1 (units)..bcd4 (thousands), overflow (saturated), done (pulse).
// Optional BIN2BCD_RATE_LIMIT_EN: at most one accept per UPDATE_DIV cycles.
module bin_to_bcd4 #(
  parameter int IN_W       = 14,
  parameter int UPDATE_DIV = 5000000
) (
  input  logic            clk_50mhz,
  input  logic            reset,
  input  logic [IN_W-1:0] bin_in,
  input  logic            bin_valid,
  output logic            bin_ready,
  output logic [3:0]      bcd1,
  output logic [3:0]      bcd2,
  output logic [3:0]      bcd3,
  output logic [3:0]      bcd4,
  output logic            overflow,
  output logic            done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  localparam logic [31:0] BCD_MAX = 32'd9999;
  // Only reachable when IN_W >= 14; truncation is harmless otherwise.
  localparam logic [IN_W-1:0] SAT_VAL = IN_W'(9999);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      out_q, out_d;
  logic             ovf_out_q, ovf_out_d;

  logic             slot_open;
  logic             idle_or_done;
  logic             accept;
  logic             sat;
  logic [IN_W-1:0]  bin_cap;
  logic [3:0]       dig;
  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_shift;

  assign idle_or_done = (state_q == S_IDLE) |
                        (state_q == S_DONE);
  assign bin_ready    = idle_or_done & slot_open;
  assign accept       = bin_valid & bin_ready;

  assign sat     = 32'(bin_in) > BCD_MAX;
  assign bin_cap = sat ? SAT_VAL : bin_in;

  // Add-3 correction on every digit >= 5, then
  // shift the binary MSB into the BCD LSB.
  always_comb begin
    dig     = '0;
    bcd_adj = '0;
    for (int i = 0; i < 4; i++) begin
      dig = bcd_q[4*i +: 4];
      bcd_adj[4*i +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    bcd_shift = (bcd_adj << 1) |
                {15'd0, bin_q[IN_W-1]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    out_d     = out_q;
    ovf_out_d = ovf_out_q;
    unique case (1'b1)
      (state_q == S_SHIFT): begin
        bin_d = bin_q << 1;
        bcd_d = bcd_shift;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          out_d     = bcd_shift;
          ovf_out_d = ovf_q;
        end
      end
      idle_or_done: begin
        if (accept) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_LOAD;
          bin_d   = bin_cap;
          bcd_d   = '0;
          ovf_d   = sat;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      out_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

`ifdef BIN2BCD_RATE_LIMIT_EN
  localparam int DIV_W =
    (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(UPDATE_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             slot_q, slot_d;
  logic             wrap;

  // A wrap opening a new slot wins over an
  // accept closing the current one.
  always_comb begin
    wrap   = (div_q == DIV_LAST);
    div_d  = wrap ? '0 : div_q + 1'b1;
    slot_d = slot_q;
    if (accept) slot_d = 1'b0;
    if (wrap)   slot_d = 1'b1;
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      div_q  <= '0;
      slot_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      slot_q <= slot_d;
    end
  end

  assign slot_open = slot_q;
`else
  assign slot_open = 1'b1;
`endif

  assign bcd1     = out_q[3:0];
  assign bcd2     = out_q[7:4];
  assign bcd3     = out_q[11:8];
  assign bcd4     = out_q[15:12];
  assign overflow = ovf_out_q;
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_bin_to_bcd4.sv
// tb_bin_to_bcd4: scoreboard bench for bin_to_bcd4.
// Define BIN2BCD_RATE_LIMIT_EN to also exercise the rate limiter.
module tb_bin_to_bcd4;

  localparam int IN_W = 14;
  localparam int DIV  = 100;

  logic            clk_50mhz = 1'b0;
  logic            reset     = 1'b0;
  logic [IN_W-1:0] bin_in    = '0;
  logic            bin_valid = 1'b0;
  logic            bin_ready;
  logic [3:0]      bcd1, bcd2, bcd3, bcd4;
  logic            overflow;
  logic            done;

  int n_vec = 0;
  int n_bad = 0;
  logic [16:0] sb_q[$];

  always #10 clk_50mhz = ~clk_50mhz;

  bin_to_bcd4 #(
    .IN_W      (IN_W),
    .UPDATE_DIV(DIV)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .reset    (reset),
    .bin_in   (bin_in),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .bcd1     (bcd1),
    .bcd2     (bcd2),
    .bcd3     (bcd3),
    .bcd4     (bcd4),
    .overflow (overflow),
    .done     (done)
  );

  function automatic logic [16:0] model(input int v);
    int   s;
    logic o;
    o = (v > 9999);
    s = o ? 9999 : v;
    return {o, 4'(s / 1000), 4'((s / 100) % 10),
            4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [16:0] dut_out();
    return {overflow, bcd4, bcd3, bcd2, bcd1};
  endfunction

  task automatic apply(input int v, output bit ok);
    int t;
    t  = 0;
    ok = 0;
    @(negedge clk_50mhz);
    while (!bin_ready && t < 40) begin
      @(negedge clk_50mhz);
      t++;
    end
    if (!bin_ready) return;
    bin_in    = IN_W'(v);
    bin_valid = 1'b1;
    sb_q.push_back(model(v));
    @(posedge clk_50mhz);
    #1;
    bin_valid = 1'b0;
    ok = 1;
  endtask

  task automatic wait_done(output bit ok, output int lat,
                           output bit stable);
    logic [16:0] ref0;
    ok     = 0;
    lat    = 0;
    stable = 1;
    ref0   = dut_out();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_50mhz);
      lat++;
      if (done) begin
        ok = 1;
        return;
      end
      if (dut_out() !== ref0) stable = 0;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    bin_valid = 1'b1;
    bin_in    = IN_W'(55);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_50mhz);
      n_vec++;
      if ({dut_out(), bin_ready, done} !== {17'd0, 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_hold c=%0d out=%h rdy=%b done=%b want 0/1/0",
                 c, dut_out(), bin_ready, done);
      end
    end
    bin_valid = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk_50mhz);
    n_vec++;
    if ({bin_ready, done, dut_out()} !== {1'b1, 1'b0, 17'd0}) begin
      n_bad++;
      $display("FAIL reset_release rdy=%b done=%b out=%h want 1/0/0",
               bin_ready, done, dut_out());
    end
  endtask

  task automatic test_latency();
    bit ok;
    int busy, lat;
    logic [16:0] exp;
    apply(1234, ok);
    busy = 0;
    lat  = 0;
    for (int i = 0; i < 40 && ok; i++) begin
      @(negedge clk_50mhz);
      lat++;
      if (done) break;
      if (!bin_ready) busy++;
    end
    n_vec++;
    if (!ok || !done || lat != 15 || busy != 14) begin
      n_bad++;
      $display("FAIL latency ok=%b lat=%0d busy=%0d want lat 15 busy 14",
               ok, lat, busy);
      sb_q.delete();
      return;
    end
    exp = sb_q.pop_front();
    n_vec++;
    if (dut_out() !== exp || bin_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL result_1234 got=%h rdy=%b want=%h rdy=1",
               dut_out(), bin_ready, exp);
    end
    @(negedge clk_50mhz);
    n_vec++;
    if (done !== 1'b0 || dut_out() !== exp) begin
      n_bad++;
      $display("FAIL done_pulse done=%b out=%h want 0 and %h",
               done, dut_out(), exp);
    end
  endtask

  task automatic test_values(input string nm, input int a,
                             input int b, input int c);
    int vals[3];
    bit ok, st;
    int lat;
    logic [16:0] exp;
    vals = '{a, b, c};
    for (int i = 0; i < 3; i++) begin
      apply(vals[i], ok);
      if (ok) wait_done(ok, lat, st);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s_timeout v=%0d got none want done", nm, vals[i]);
        sb_q.delete();
        continue;
      end
      exp = sb_q.pop_front();
      if (dut_out() !== exp) begin
        n_bad++;
        $display("FAIL %s_value v=%0d got=%h want=%h",
                 nm, vals[i], dut_out(), exp);
      end
      n_vec++;
      if (!st) begin
        n_bad++;
        $display("FAIL %s_stable v=%0d got changed want held",
                 nm, vals[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int last, got;
    bit ok, st;
    int lat;
    logic [16:0] exp;
    last = -1;
    got  = 0;
    @(negedge clk_50mhz);
    bin_valid = 1'b1;
    for (int c = 0; c < 120 && got < 4; c++) begin
      bin_in = IN_W'(100 + c);
      if (done) begin
        exp = sb_q.pop_front();
        got++;
        n_vec++;
        if (dut_out() !== exp) begin
          n_bad++;
          $display("FAIL b2b_value n=%0d got=%h want=%h",
                   got, dut_out(), exp);
        end
      end
      if (bin_ready) begin
        sb_q.push_back(model(100 + c));
        if (last >= 0) begin
          n_vec++;
          if (c - last != 15) begin
            n_bad++;
            $display("FAIL b2b_spacing got=%0d want=15", c - last);
          end
        end
        last = c;
      end
      @(negedge clk_50mhz);
    end
    bin_valid = 1'b0;
    n_vec++;
    if (got != 4) begin
      n_bad++;
      $display("FAIL b2b_count got=%0d want=4", got);
    end
    while (sb_q.size() > 0) begin
      wait_done(ok, lat, st);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL b2b_drain got none want done");
        sb_q.delete();
        break;
      end
      exp = sb_q.pop_front();
      if (dut_out() !== exp) begin
        n_bad++;
        $display("FAIL b2b_drain got=%h want=%h", dut_out(), exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, st, seen;
    int lat;
    logic [16:0] exp;
    apply(777, ok);
    repeat (6) @(negedge clk_50mhz);
    reset = 1'b0;
    #1;
    n_vec++;
    if ({dut_out(), bin_ready, done} !== {17'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset out=%h rdy=%b done=%b want 0/1/0",
               dut_out(), bin_ready, done);
    end
    sb_q.delete();
    repeat (3) @(negedge clk_50mhz);
    reset = 1'b1;
    seen  = 0;
    @(negedge clk_50mhz);
    n_vec++;
    if (bin_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_ready got=%b want=1", bin_ready);
    end
    for (int i = 0; i < 20; i++) begin
      if (done) seen = 1;
      @(negedge clk_50mhz);
    end
    n_vec++;
    if (seen || dut_out() !== 17'd0) begin
      n_bad++;
      $display("FAIL mid_abort done_seen=%b out=%h want 0/0",
               seen, dut_out());
    end
    apply(321, ok);
    if (ok) wait_done(ok, lat, st);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL mid_after got none want done");
      sb_q.delete();
    end else begin
      exp = sb_q.pop_front();
      if (dut_out() !== exp) begin
        n_bad++;
        $display("FAIL mid_after got=%h want=%h", dut_out(), exp);
      end
    end
  endtask

`ifdef BIN2BCD_RATE_LIMIT_EN
  task automatic test_rate_limit();
    int last, nacc;
    logic [16:0] exp;
    @(negedge clk_50mhz);
    reset     = 1'b0;
    bin_valid = 1'b1;
    sb_q.delete();
    repeat (2) @(negedge clk_50mhz);
    reset = 1'b1;
    last  = -1;
    nacc  = 0;
    for (int c = 0; c < 320; c++) begin
      bin_in = IN_W'(4000 + c);
      if (done && sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        n_vec++;
        if (dut_out() !== exp) begin
          n_bad++;
          $display("FAIL rate_value got=%h want=%h", dut_out(), exp);
        end
      end
      if (bin_ready) begin
        sb_q.push_back(model(4000 + c));
        n_vec++;
        if ((last < 0 && c != 0) || (last >= 0 && c - last != DIV)) begin
          n_bad++;
          $display("FAIL rate_spacing at=%0d prev=%0d want first 0 step %0d",
                   c, last, DIV);
        end
        last = c;
        nacc++;
      end
      @(negedge clk_50mhz);
    end
    bin_valid = 1'b0;
    n_vec++;
    if (nacc != 4) begin
      n_bad++;
      $display("FAIL rate_count got=%0d want=4", nacc);
    end
    repeat (20) @(negedge clk_50mhz);
    sb_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_values("seq", 9999, 0, 5);
    test_values("ovf", 12000, 42, 16383);
    test_back_to_back();
    test_reset_mid();
`ifdef BIN2BCD_RATE_LIMIT_EN
    test_rate_limit();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
